md5_block_builder: RTL and testbench
====================================

// Module: md5_block_builder
// PURPOSE
// - Upstream feeder of the MD5 engine. Stores a secret key received as a byte stream.
// - Then emits one padded 512-bit MD5 block per candidate: key || decimal(N), for N = 1, 2, 3, ...
// - The engine returns the first 128 block bits as its result header, so key+digits fit in 16 bytes.
// PARAMETERS
// - BLOCK_WIDTH    512  MD5 block width in bits; fixed at 512.
// - MAX_KEY_BYTES  8    key capacity in bytes.
// - MAX_DIGITS     8    max decimal digits of N; MAX_KEY_BYTES+MAX_DIGITS <= 16 (elaboration assertion).
// PORTS
// - clk              in   1    single clock.
// - reset_n          in   1    asynchronous reset, active-low.
// - key_ready        out  1    high in IDLE only.
// - key_valid        in   1    key byte strobe.
// - key_byte         in   8    key byte (ASCII), first byte first.
// - key_last         in   1    marks the final key byte.
// - stop             in   1    result found; end generation (pulse or level).
// - md5_block_ready  in   1    engine accepts a block.
// - md5_block_valid  out  1    block offered.
// - md5_block_data   out  512  padded block; message byte i at [511-8*i -: 8].
// - done             out  1    generation finished (sticky until reset).
// - overflow         out  1    N exceeded MAX_DIGITS digits (sticky until reset).
// BEHAVIOUR
// - Reset (async assert, sync deassert handled upstream):
//   - state=IDLE, key_len=0, digits=BCD "1", ndigits=1, stop_pending=0.
//   - Outputs: md5_block_valid=0, md5_block_data=0, done=0, overflow=0, key_ready=1.
// - States: IDLE -> FORMAT -> OFFER -> (FORMAT | DONE).
// - IDLE: on key_valid, store key_byte at index key_len and increment key_len.
//   - Bytes beyond MAX_KEY_BYTES are dropped; key_len saturates.
//   - key_valid&key_last -> FORMAT. Minimum key length is 1.
// - FORMAT (1 cycle, md5_block_valid=0): register md5_block_data from key, digits and ndigits.
//   - L = key_len + ndigits.
//   - Bytes 0..key_len-1 = key.
//   - Bytes key_len..L-1 = 8'h30+digit, most significant digit first.
//   - Byte L = 8'h80; bytes L+1..55 = 0.
//   - Bytes 56..63 = 64-bit little-endian bit length 8*L: byte56 = (8L)[7:0], byte57 = (8L)[15:8], rest 0.
//   - Next state: OFFER.
// - OFFER: md5_block_valid=1. Data and valid are held stable until md5_block_ready.
//   - On handshake, BCD-increment N with ripple carry from the least significant digit.
//   - All-9s carry: ndigits+1 and digits become "1" followed by zeros.
//   - Next state after handshake:
//     - Carry with ndigits==MAX_DIGITS -> DONE and overflow=1.
//     - Else stop_pending, or stop in the same cycle -> DONE.
//     - Else -> FORMAT.
// - stop: sampled in FORMAT or OFFER and sets stop_pending. The current block is always completed; valid never drops without a handshake.
//   - In IDLE, stop is ignored. In DONE it has no effect.
// - DONE: md5_block_valid=0, done=1. Terminal until reset.
// - Throughput: 1 block per 2 cycles plus engine backpressure.
// - Reset mid-OFFER: md5_block_valid clears immediately (async). Key is lost; reload required.
// TESTING
// - Key "abcdef" (6 bytes, last on 'f'), ready=1:
//   - 2 cycles after key_last, valid=1.
//   - md5_block_data[511-:64] = 64'h6162636465663180.
//   - byte56 = 8'h38, all other bytes 0.
// - ready=0 for 10 cycles in OFFER: valid stays 1, data bit-identical every cycle.
//   - ready=1: the next block is "abcdef2".
// - 10th handshake: block "abcdef10": byte8 = 8'h80, byte56 = 8'h40, byte7 = 8'h30.
// - stop pulsed 1 cycle in OFFER with ready=0:
//   - Valid held until ready; after the handshake, DONE: done=1, valid=0.
//   - No further blocks.
// - MAX_DIGITS=2, key "k": after the block with N=99 is accepted -> DONE, overflow=1, done=1.
// - reset_n low during OFFER: same-cycle valid=0, key_ready=1.
//   - A new key "xy" yields a first block of "xy1".

Source files
------------

// File: rtl/md5_block_builder.sv
// md5_block_builder: stores a secret key from a byte stream, then emits one
// padded 512-bit MD5 block per candidate key || decimal(N), N = 1, 2, 3, ...
module md5_block_builder #(
  parameter int unsigned BLOCK_WIDTH   = 512,
  parameter int unsigned MAX_KEY_BYTES = 8,
  parameter int unsigned MAX_DIGITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   key_ready,
  input  logic                   key_valid,
  input  logic [7:0]             key_byte,
  input  logic                   key_last,
  input  logic                   stop,
  input  logic                   md5_block_ready,
  output logic                   md5_block_valid,
  output logic [BLOCK_WIDTH-1:0] md5_block_data,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned KL_W = $clog2(MAX_KEY_BYTES + 1);
  localparam int unsigned ND_W = $clog2(MAX_DIGITS + 1);

  // Key plus digits must fit in the 128-bit result header the engine returns.
  if (BLOCK_WIDTH != 512) begin : g_bad_width
    $error("md5_block_builder: BLOCK_WIDTH must be 512");
  end
  if (MAX_KEY_BYTES + MAX_DIGITS > 16) begin : g_bad_capacity
    $error("md5_block_builder: MAX_KEY_BYTES + MAX_DIGITS must not exceed 16");
  end
  if (MAX_KEY_BYTES < 1 || MAX_DIGITS < 1) begin : g_bad_min
    $error("md5_block_builder: MAX_KEY_BYTES and MAX_DIGITS must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FORMAT,
    S_OFFER,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             key_q [MAX_KEY_BYTES];
  logic [7:0]             key_d [MAX_KEY_BYTES];
  logic [KL_W-1:0]        key_len_q, key_len_d;
  // BCD counter, index 0 is the least significant digit
  logic [3:0]             digits_q [MAX_DIGITS];
  logic [3:0]             digits_d [MAX_DIGITS];
  logic [ND_W-1:0]        ndigits_q, ndigits_d;
  logic                   stop_pending_q, stop_pending_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic                   key_ready_q, key_ready_d;
  logic [BLOCK_WIDTH-1:0] data_q, data_d;

  logic [31:0]            klen_i;
  logic [31:0]            nd_i;
  logic [31:0]            msg_len;
  logic [15:0]            bit_len;
  logic [BLOCK_WIDTH-1:0] fmt_block;
  logic [3:0]             inc_digits [MAX_DIGITS];
  logic                   all_nines;
  logic                   digits_full;

  assign klen_i      = 32'(key_len_q);
  assign nd_i        = 32'(ndigits_q);
  assign msg_len     = klen_i + nd_i;
  assign bit_len     = 16'(msg_len * 32'd8);
  assign digits_full = (ndigits_q == ND_W'(MAX_DIGITS));

  // Assemble the padded block: key, ASCII digits MSD first, 0x80, zero fill, LE bit length
  always_comb begin
    fmt_block = '0;
    for (int unsigned i = 0; i < MAX_KEY_BYTES; i++) begin
      if (i < klen_i) begin
        fmt_block[BLOCK_WIDTH-1-8*i -: 8] = key_q[i];
      end
    end
    // digit j (LSD = 0) lands at byte msg_len-1-j so the MSD comes first
    for (int unsigned j = 0; j < MAX_DIGITS; j++) begin
      if (j < nd_i) begin
        fmt_block[BLOCK_WIDTH-1-8*(msg_len-1-j) -: 8] = {4'h3, digits_q[j]};
      end
    end
    fmt_block[BLOCK_WIDTH-1-8*msg_len -: 8] = 8'h80;
    fmt_block[BLOCK_WIDTH-1-8*56 -: 8]      = bit_len[7:0];
    fmt_block[BLOCK_WIDTH-1-8*57 -: 8]      = bit_len[15:8];
  end

  // BCD increment with ripple carry; an all-9s value grows by one digit as "10..0"
  always_comb begin
    inc_digits = digits_q;
    all_nines  = 1'b1;
    for (int unsigned j = 0; j < MAX_DIGITS; j++) begin
      if (all_nines && (j < nd_i)) begin
        if (digits_q[j] == 4'd9) begin
          inc_digits[j] = 4'd0;
        end else begin
          inc_digits[j] = digits_q[j] + 4'd1;
          all_nines     = 1'b0;
        end
      end
    end
    if (all_nines && !digits_full) begin
      for (int unsigned j = 0; j < MAX_DIGITS; j++) begin
        if (j == nd_i) begin
          inc_digits[j] = 4'd1;
        end
      end
    end
  end

  // Next-state and registered-output computation for the key/format/offer FSM
  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    key_len_d      = key_len_q;
    digits_d       = digits_q;
    ndigits_d      = ndigits_q;
    stop_pending_d = stop_pending_q;
    data_d         = data_q;
    overflow_d     = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if (key_len_q != KL_W'(MAX_KEY_BYTES)) begin
            for (int unsigned i = 0; i < MAX_KEY_BYTES; i++) begin
              if (i == klen_i) begin
                key_d[i] = key_byte;
              end
            end
            key_len_d = key_len_q + KL_W'(1);
          end
          if (key_last) begin
            state_d = S_FORMAT;
          end
        end
      end
      S_FORMAT: begin
        data_d  = fmt_block;
        state_d = S_OFFER;
        if (stop) begin
          stop_pending_d = 1'b1;
        end
      end
      S_OFFER: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (md5_block_ready) begin
          digits_d = inc_digits;
          if (all_nines && digits_full) begin
            state_d    = S_DONE;
            overflow_d = 1'b1;
          end else begin
            if (all_nines) begin
              ndigits_d = ndigits_q + ND_W'(1);
            end
            state_d = (stop_pending_q || stop) ? S_DONE : S_FORMAT;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d     = (state_d == S_OFFER);
    done_d      = (state_d == S_DONE);
    key_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      key_q          <= '{default: '0};
      key_len_q      <= '0;
      digits_q       <= '{default: '0};
      digits_q[0]    <= 4'd1;
      ndigits_q      <= ND_W'(1);
      stop_pending_q <= 1'b0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      key_ready_q    <= 1'b1;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      key_len_q      <= key_len_d;
      digits_q       <= digits_d;
      ndigits_q      <= ndigits_d;
      stop_pending_q <= stop_pending_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      overflow_q     <= overflow_d;
      key_ready_q    <= key_ready_d;
      data_q         <= data_d;
    end
  end

  assign key_ready       = key_ready_q;
  assign md5_block_valid = valid_q;
  assign md5_block_data  = data_q;
  assign done            = done_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_md5_block_builder.sv
// tb_md5_block_builder: randomized bench for md5_block_builder with a
// string-level reference model of the padded candidate block.
module tb_md5_block_builder;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         reset_n;
  logic         kv1, kl1, stop1, ready1;
  logic [7:0]   kb1;
  logic         kready1, valid1, done1, ovf1;
  logic [511:0] data1;
  logic         kv2, kl2, stop2, ready2;
  logic [7:0]   kb2;
  logic         kready2, valid2, done2, ovf2;
  logic [511:0] data2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md5_block_builder #(.BLOCK_WIDTH(512), .MAX_KEY_BYTES(8), .MAX_DIGITS(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .key_ready(kready1), .key_valid(kv1),
    .key_byte(kb1), .key_last(kl1), .stop(stop1), .md5_block_ready(ready1),
    .md5_block_valid(valid1), .md5_block_data(data1), .done(done1), .overflow(ovf1)
  );

  md5_block_builder #(.BLOCK_WIDTH(512), .MAX_KEY_BYTES(8), .MAX_DIGITS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .key_ready(kready2), .key_valid(kv2),
    .key_byte(kb2), .key_last(kl2), .stop(stop2), .md5_block_ready(ready2),
    .md5_block_valid(valid2), .md5_block_data(data2), .done(done2), .overflow(ovf2)
  );

  // Reference: message = first maxk key bytes followed by the decimal text of n
  function automatic logic [511:0] model_block(input bq_t key, input int unsigned n,
                                               input int unsigned maxk);
    logic [7:0]   msg[$];
    string        s;
    logic [511:0] blk;
    int unsigned  len;
    logic [15:0]  bits;
    s = $sformatf("%0d", n);
    for (int i = 0; i < key.size() && i < int'(maxk); i++) msg.push_back(key[i]);
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    blk = '0;
    len = msg.size();
    for (int i = 0; i < int'(len); i++) blk[511-8*i -: 8] = msg[i];
    blk[511-8*len -: 8] = 8'h80;
    bits = 16'(8 * len);
    blk[511-8*56 -: 8] = bits[7:0];
    blk[511-8*57 -: 8] = bits[15:8];
    return blk;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic clear_inputs();
    kv1 = 0; kl1 = 0; kb1 = 0; stop1 = 0; ready1 = 0;
    kv2 = 0; kl2 = 0; kb2 = 0; stop2 = 0; ready2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic load_key(input int sel, input bq_t kb);
    for (int i = 0; i < kb.size(); i++) begin
      if (sel == 0) begin kv1 = 1; kb1 = kb[i]; kl1 = (i == kb.size() - 1); end
      else          begin kv2 = 1; kb2 = kb[i]; kl2 = (i == kb.size() - 1); end
      @(negedge clk);
    end
    kv1 = 0; kl1 = 0; kv2 = 0; kl2 = 0;
  endtask

  task automatic wait_valid(input int sel, input string tag, output bit ok);
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (((sel == 0) ? valid1 : valid2) === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: valid never rose within 40 cycles", tag);
    end
  endtask

  task automatic accept(input int sel);
    if (sel == 0) ready1 = 1; else ready2 = 1;
    @(negedge clk);
    ready1 = 0; ready2 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid1); end
    total++; if (data1 !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", data1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ovf1); end
    total++; if (kready1 !== 1'b1) begin bad++; $display("FAIL reset_key_ready: got %b want 1", kready1); end
  endtask

  task automatic test_abcdef();
    bq_t          key;
    logic [511:0] snap, exp;
    bit           ok;
    int           st;
    key = str2q("abcdef");
    load_key(0, key);
    total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL latency_early: valid got %b want 0", valid1); end
    @(negedge clk);
    total++; if (valid1 !== 1'b1) begin bad++; $display("FAIL latency: valid got %b want 1", valid1); end
    total++; if (data1[511-:64] !== 64'h6162636465663180) begin
      bad++; $display("FAIL abcdef1_head: got %h want 6162636465663180", data1[511-:64]); end
    total++; if (data1[511-8*56 -: 8] !== 8'h38) begin
      bad++; $display("FAIL abcdef1_len: got %h want 38", data1[511-8*56 -: 8]); end
    exp = model_block(key, 1, 8);
    total++; if (data1 !== exp) begin bad++; $display("FAIL abcdef1_block: got %h want %h", data1, exp); end
    total++; if (kready1 !== 1'b0) begin bad++; $display("FAIL key_ready_offer: got %b want 0", kready1); end
    snap = data1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (valid1 !== 1'b1 || data1 !== snap) begin
        bad++; $display("FAIL stall_hold: valid %b data %h want valid 1 data %h", valid1, data1, snap);
      end
    end
    accept(0);
    for (int unsigned n = 2; n <= 10; n++) begin
      wait_valid(0, "abcdef_wait", ok);
      exp = model_block(key, n, 8);
      total++; if (data1 !== exp) begin bad++; $display("FAIL abcdef%0d_block: got %h want %h", n, data1, exp); end
      if (n == 10) begin
        total++; if (data1[511-8*8 -: 8] !== 8'h80) begin bad++; $display("FAIL n10_pad: got %h want 80", data1[511-8*8 -: 8]); end
        total++; if (data1[511-8*56 -: 8] !== 8'h40) begin bad++; $display("FAIL n10_len: got %h want 40", data1[511-8*56 -: 8]); end
        total++; if (data1[511-8*7 -: 8] !== 8'h30) begin bad++; $display("FAIL n10_digit: got %h want 30", data1[511-8*7 -: 8]); end
      end
      st = $urandom_range(0, 2);
      snap = data1;
      repeat (st) begin
        @(negedge clk);
        total++;
        if (valid1 !== 1'b1 || data1 !== snap) begin
          bad++; $display("FAIL random_stall: valid %b data %h want valid 1 data %h", valid1, data1, snap);
        end
      end
      accept(0);
    end
  endtask

  task automatic test_stop();
    bit ok;
    logic [511:0] exp;
    wait_valid(0, "stop_wait", ok);
    exp = model_block(str2q("abcdef"), 11, 8);
    total++; if (data1 !== exp) begin bad++; $display("FAIL abcdef11_block: got %h want %h", data1, exp); end
    stop1 = 1;
    @(negedge clk);
    stop1 = 0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (valid1 !== 1'b1 || done1 !== 1'b0) begin
        bad++; $display("FAIL stop_hold: valid %b done %b want valid 1 done 0", valid1, done1);
      end
    end
    accept(0);
    repeat (5) begin
      total++;
      if (valid1 !== 1'b0 || done1 !== 1'b1 || ovf1 !== 1'b0) begin
        bad++; $display("FAIL stop_done: valid %b done %b ovf %b want 0 1 0", valid1, done1, ovf1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_keys();
    bq_t          key;
    logic [511:0] exp;
    bit           ok;
    int           len, nb, mode;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      key.delete();
      len = (it == 0) ? 10 : $urandom_range(1, 10);
      for (int i = 0; i < len; i++) key.push_back(8'($urandom_range(33, 126)));
      mode = it % 2;
      nb = $urandom_range(2, 6);
      load_key(0, key);
      for (int n = 1; n <= nb; n++) begin
        wait_valid(0, "rand_wait", ok);
        exp = model_block(key, n, 8);
        total++; if (data1 !== exp) begin bad++; $display("FAIL rand_block it%0d n%0d: got %h want %h", it, n, data1, exp); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (n == nb && mode == 0) begin
          stop1 = 1; ready1 = 1;
          @(negedge clk);
          stop1 = 0; ready1 = 0;
        end else begin
          accept(0);
          if (n == nb - 1 && mode == 1) begin
            stop1 = 1;
            @(negedge clk);
            stop1 = 0;
          end
        end
      end
      repeat (2) begin
        total++;
        if (done1 !== 1'b1 || valid1 !== 1'b0) begin
          bad++; $display("FAIL rand_done it%0d: done %b valid %b want 1 0", it, done1, valid1);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_overflow();
    bq_t          key;
    logic [511:0] exp;
    bit           ok;
    do_reset();
    key = str2q("k");
    load_key(1, key);
    for (int unsigned n = 1; n <= 99; n++) begin
      wait_valid(1, "ovf_wait", ok);
      exp = model_block(key, n, 8);
      total++; if (data2 !== exp) begin bad++; $display("FAIL ovf_block n%0d: got %h want %h", n, data2, exp); end
      if (n == 99) begin
        total++; if (ovf2 !== 1'b0 || done2 !== 1'b0) begin
          bad++; $display("FAIL ovf_early: ovf %b done %b want 0 0", ovf2, done2); end
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
      accept(1);
    end
    total++;
    if (ovf2 !== 1'b1 || done2 !== 1'b1 || valid2 !== 1'b0) begin
      bad++; $display("FAIL ovf_final: ovf %b done %b valid %b want 1 1 0", ovf2, done2, valid2);
    end
  endtask

  task automatic test_reset_mid_offer();
    bq_t          key;
    logic [511:0] exp;
    bit           ok;
    do_reset();
    key = str2q("xy");
    load_key(0, key);
    wait_valid(0, "mid_wait", ok);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    total++; if (valid1 !== 1'b0 || kready1 !== 1'b1) begin
      bad++; $display("FAIL async_reset: valid %b key_ready %b want 0 1", valid1, kready1); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    load_key(0, key);
    wait_valid(0, "reload_wait", ok);
    exp = model_block(key, 1, 8);
    total++; if (data1 !== exp) begin bad++; $display("FAIL reload_block: got %h want %h", data1, exp); end
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    test_reset();
    test_abcdef();
    test_stop();
    test_random_keys();
    test_overflow();
    test_reset_mid_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
